// File: rtl/shared_detect_sched.sv
// shared_detect_sched
//   Round-robin arbiter that grants one requester at a time a frame on a
//   shared serial path, and counts every third '1' seen on the granted
//   requester's data bit during that frame.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req[3:0]   per-requester request, held high for the whole frame
//   bit_in[3:0] per-requester serial data bit (only the owner's is used)
//   last[3:0]  per-requester end-of-frame marker
//   gnt[3:0]   registered one-hot grant, zero when nobody owns the path
//   owner[1:0] registered index of the grantee, meaningful while |gnt
//   det        combinational pulse on every third '1' of the granted frame
//   done       registered one-cycle frame-complete pulse
//   trip_cnt   det pulses counted in the finished frame (valid with done)
//   aborted    with done: 1 when the frame ended because req dropped
//   state_dbg  current arbiter state, for observation only
//
// Handshake: a requester raises req[i] and keeps it high; gnt[i] rising is
// the acceptance. Every cycle with gnt[i]=1 and req[i]=1 is one consumed
// beat of bit_in[i]/last[i]. Lowering req[i] while granted abandons the
// frame; that cycle's beat is discarded. After each frame the path is idle
// for two cycles (GAP, IDLE) before the next grant.

module shared_detect_sched #(
   parameter int MAX_BEATS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] bit_in,
   input  logic [3:0] last,
   output logic [3:0] gnt,
   output logic [1:0] owner,
   output logic       det,
   output logic       done,
   output logic [3:0] trip_cnt,
   output logic       aborted,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2
   } phase_t;

   localparam logic [3:0] LAST_BEAT = 4'(MAX_BEATS - 1);

   state_t     state_q, state_d;
   phase_t     phase_q, phase_d, phase_after;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] beat_q, beat_d;
   logic [3:0] acc_q, acc_d, acc_after;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] owner_q, owner_d;
   logic       done_q, done_d;
   logic [3:0] trip_q, trip_d;
   logic       abort_q, abort_d;

   logic       pick_valid;
   logic [1:0] pick_idx;
   logic [1:0] cand;
   logic       own_bit, own_req, own_last;
   logic       det_c;

   // Round-robin search starting at ptr. Walking the offsets from highest
   // to lowest lets the lowest offset with a request overwrite the rest.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = 2'd0;
      cand       = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_q + 2'(k);
         if (req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign own_bit  = bit_in[owner_q];
   assign own_req  = req[owner_q];
   assign own_last = last[owner_q];

   // A dropped request suppresses the pulse even when the bit would complete
   // a group of three; that beat is not part of the frame.
   assign det_c = (state_q == RUN) && (phase_q == P2) && own_bit && own_req;

   always_comb begin
      phase_after = phase_q;
      if (own_bit) begin
         case (phase_q)
            P0:      phase_after = P1;
            P1:      phase_after = P2;
            default: phase_after = P0;
         endcase
      end
   end

   assign acc_after = (det_c && (acc_q != 4'd15)) ? acc_q + 4'd1 : acc_q;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      ptr_d   = ptr_q;
      beat_d  = beat_q;
      acc_d   = acc_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      done_d  = 1'b0;
      trip_d  = 4'd0;
      abort_d = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_d = 4'd0;
            if (pick_valid) begin
               state_d = RUN;
               gnt_d   = 4'b0001 << pick_idx;
               owner_d = pick_idx;
               beat_d  = 4'd0;
               phase_d = P0;
               acc_d   = 4'd0;
            end
         end
         RUN: begin
            if (!own_req) begin
               // Abort wins over a simultaneous last: beat is discarded.
               state_d = GAP;
               gnt_d   = 4'd0;
               done_d  = 1'b1;
               abort_d = 1'b1;
               trip_d  = acc_q;
            end else begin
               phase_d = phase_after;
               acc_d   = acc_after;
               beat_d  = beat_q + 4'd1;
               if (own_last || (beat_q == LAST_BEAT)) begin
                  state_d = GAP;
                  gnt_d   = 4'd0;
                  done_d  = 1'b1;
                  trip_d  = acc_after;
               end
            end
         end
         GAP: begin
            gnt_d   = 4'd0;
            ptr_d   = owner_q + 2'd1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= P0;
         ptr_q   <= 2'd0;
         beat_q  <= 4'd0;
         acc_q   <= 4'd0;
         gnt_q   <= 4'd0;
         owner_q <= 2'd0;
         done_q  <= 1'b0;
         trip_q  <= 4'd0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         ptr_q   <= ptr_d;
         beat_q  <= beat_d;
         acc_q   <= acc_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         done_q  <= done_d;
         trip_q  <= trip_d;
         abort_q <= abort_d;
      end
   end

   assign gnt       = gnt_q;
   assign owner     = owner_q;
   assign det       = det_c;
   assign done      = done_q;
   assign trip_cnt  = trip_q;
   assign aborted   = abort_q;
   assign state_dbg = state_q;

endmodule
